// File: rtl/gen_reg_file.sv
// General-purpose register file with two read ports, per-register clear/load/inc/dec,
// a sticky overflow flag and a shadow bank supporting snapshot, restore and swap.
module gen_reg_file #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREG  = 8,
  parameter int unsigned SAT   = 0,
  localparam int unsigned SW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       FunSel,
  input  logic [NREG-1:0]  RSel,
  input  logic [WIDTH-1:0] I,
  input  logic [SW-1:0]    O1Sel,
  input  logic [SW-1:0]    O2Sel,
  input  logic             Snap,
  input  logic             Restore,
  input  logic             ClrOvf,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic             Z1,
  output logic             Ovf
);

  typedef enum logic [1:0] {
    FN_CLR  = 2'd0,
    FN_LOAD = 2'd1,
    FN_DEC  = 2'd2,
    FN_INC  = 2'd3
  } fun_e;

  logic [WIDTH-1:0] regs_q   [NREG];
  logic [WIDTH-1:0] regs_d   [NREG];
  logic [WIDTH-1:0] shadow_q [NREG];
  logic [WIDTH-1:0] shadow_d [NREG];
  logic             ovf_q;
  logic             ovf_d;
  logic             ovf_set;
  fun_e             fun;

  assign fun = fun_e'(FunSel);

  // Snap samples pre-edge registers; Restore reads pre-edge shadow, so both together swap.
  always_comb begin
    regs_d   = regs_q;
    shadow_d = shadow_q;
    ovf_set  = 1'b0;
    if (Snap) begin
      shadow_d = regs_q;
    end
    if (Restore) begin
      regs_d = shadow_q;
    end else begin
      for (int unsigned k = 0; k < NREG; k++) begin
        if (!RSel[k]) begin
          unique case (fun)
            FN_CLR:  regs_d[k] = '0;
            FN_LOAD: regs_d[k] = I;
            FN_DEC: begin
              if (regs_q[k] == '0) begin
                ovf_set   = 1'b1;
                regs_d[k] = (SAT != 0) ? '0 : '1;
              end else begin
                regs_d[k] = regs_q[k] - WIDTH'(1);
              end
            end
            FN_INC: begin
              if (regs_q[k] == '1) begin
                ovf_set   = 1'b1;
                regs_d[k] = (SAT != 0) ? '1 : '0;
              end else begin
                regs_d[k] = regs_q[k] + WIDTH'(1);
              end
            end
            default: regs_d[k] = regs_q[k];
          endcase
        end
      end
    end
    ovf_d = ovf_set | (ovf_q & ~ClrOvf);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 0; k < NREG; k++) begin
        regs_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign O1  = regs_q[O1Sel];
  assign O2  = regs_q[O2Sel];
  assign Z1  = (O1 == '0);
  assign Ovf = ovf_q;

endmodule

// File: tb/tb_gen_reg_file.sv
// Directed self-checking bench for gen_reg_file: a wrapping instance and a
// saturating instance share all inputs.
module tb_gen_reg_file;

  logic       clk;
  logic       rst;
  logic [1:0] fun_sel;
  logic [7:0] r_sel;
  logic [7:0] i_data;
  logic [2:0] o1_sel;
  logic [2:0] o2_sel;
  logic       snap;
  logic       restore;
  logic       clr_ovf;
  logic [7:0] o1_a, o2_a, o1_b, o2_b;
  logic       z1_a, ovf_a, z1_b, ovf_b;

  int tests;
  int fails;

  gen_reg_file #(.WIDTH(8), .NREG(8), .SAT(0)) dut_a (
    .CLK(clk), .RST(rst), .FunSel(fun_sel), .RSel(r_sel), .I(i_data),
    .O1Sel(o1_sel), .O2Sel(o2_sel), .Snap(snap), .Restore(restore), .ClrOvf(clr_ovf),
    .O1(o1_a), .O2(o2_a), .Z1(z1_a), .Ovf(ovf_a)
  );

  gen_reg_file #(.WIDTH(8), .NREG(8), .SAT(1)) dut_b (
    .CLK(clk), .RST(rst), .FunSel(fun_sel), .RSel(r_sel), .I(i_data),
    .O1Sel(o1_sel), .O2Sel(o2_sel), .Snap(snap), .Restore(restore), .ClrOvf(clr_ovf),
    .O1(o1_b), .O2(o2_b), .Z1(z1_b), .Ovf(ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fun_sel = 2'd0;
    r_sel   = 8'hFF;
    i_data  = 8'h00;
    snap    = 1'b0;
    restore = 1'b0;
    clr_ovf = 1'b0;
  endtask

  task automatic load(input logic [2:0] idx, input logic [7:0] val);
    idle();
    r_sel       = 8'hFF;
    r_sel[idx]  = 1'b0;
    fun_sel     = 2'd1;
    i_data      = val;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    o1_sel = 3'd0;
    o2_sel = 3'd7;
    #1;
    tests++; if (o1_a !== 8'h00 || o2_a !== 8'h00) begin fails++; $display("FAIL reset_out O1=%h O2=%h exp=00/00", o1_a, o2_a); end
    tests++; if (z1_a !== 1'b1 || ovf_a !== 1'b0) begin fails++; $display("FAIL reset_flags Z1=%b Ovf=%b exp=1/0", z1_a, ovf_a); end
    r_sel   = 8'h00;
    fun_sel = 2'd1;
    i_data  = 8'h77;
    tick();
    tests++; if (o1_a !== 8'h00 || o2_a !== 8'h00) begin fails++; $display("FAIL reset_ignore O1=%h O2=%h exp=00/00", o1_a, o2_a); end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_load();
    r_sel   = 8'hFE;
    fun_sel = 2'd1;
    i_data  = 8'h5A;
    tick();
    idle();
    o1_sel = 3'd0;
    #1;
    tests++; if (o1_a !== 8'h5A || z1_a !== 1'b0) begin fails++; $display("FAIL load_r0 O1=%h Z1=%b exp=5a/0", o1_a, z1_a); end
    for (int k = 1; k < 8; k++) begin
      o2_sel = 3'(k);
      #1;
      tests++; if (o2_a !== 8'h00) begin fails++; $display("FAIL load_other r%0d=%h exp=00", k, o2_a); end
    end
  endtask

  task automatic test_inc_overflow();
    load(3'd3, 8'hFF);
    o1_sel  = 3'd3;
    r_sel   = 8'hF7;
    fun_sel = 2'd3;
    tick();
    idle();
    tests++; if (o1_a !== 8'h00 || ovf_a !== 1'b1) begin fails++; $display("FAIL inc_wrap r3=%h Ovf=%b exp=00/1", o1_a, ovf_a); end
    tests++; if (o1_b !== 8'hFF || ovf_b !== 1'b1) begin fails++; $display("FAIL inc_sat r3=%h Ovf=%b exp=ff/1", o1_b, ovf_b); end
    tick();
    tests++; if (ovf_a !== 1'b1) begin fails++; $display("FAIL ovf_sticky Ovf=%b exp=1", ovf_a); end
    clr_ovf = 1'b1;
    tick();
    idle();
    tests++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin fails++; $display("FAIL clr_ovf a=%b b=%b exp=0/0", ovf_a, ovf_b); end
  endtask

  task automatic test_dec_clrovf();
    o1_sel  = 3'd1;
    r_sel   = 8'hFD;
    fun_sel = 2'd2;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    tests++; if (o1_a !== 8'hFF || ovf_a !== 1'b1) begin fails++; $display("FAIL dec_wrap_setwins r1=%h Ovf=%b exp=ff/1", o1_a, ovf_a); end
    tests++; if (o1_b !== 8'h00 || ovf_b !== 1'b1) begin fails++; $display("FAIL dec_sat r1=%h Ovf=%b exp=00/1", o1_b, ovf_b); end
    tick();
    tests++; if (o1_a !== 8'hFE) begin fails++; $display("FAIL dec_plain r1=%h exp=fe", o1_a); end
    fun_sel = 2'd3;
    tick();
    tests++; if (o1_a !== 8'hFF) begin fails++; $display("FAIL inc_plain r1=%h exp=ff", o1_a); end
    fun_sel = 2'd0;
    tick();
    tests++; if (o1_a !== 8'h00 || z1_a !== 1'b1) begin fails++; $display("FAIL clear r1=%h Z1=%b exp=00/1", o1_a, z1_a); end
    idle();
    clr_ovf = 1'b1;
    tick();
    idle();
    tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL clr_ovf2 Ovf=%b exp=0", ovf_a); end
  endtask

  task automatic test_snap_restore();
    o1_sel = 3'd0;
    o2_sel = 3'd2;
    load(3'd0, 8'h11);
    snap = 1'b1;
    tick();
    idle();
    load(3'd0, 8'h22);
    tests++; if (o1_a !== 8'h22) begin fails++; $display("FAIL reload r0=%h exp=22", o1_a); end
    restore = 1'b1;
    tick();
    idle();
    tests++; if (o1_a !== 8'h11) begin fails++; $display("FAIL restore r0=%h exp=11", o1_a); end
    snap    = 1'b1;
    r_sel   = 8'hFE;
    fun_sel = 2'd1;
    i_data  = 8'h33;
    tick();
    idle();
    tests++; if (o1_a !== 8'h33) begin fails++; $display("FAIL snap_write r0=%h exp=33", o1_a); end
    load(3'd2, 8'hFF);
    restore = 1'b1;
    r_sel   = 8'h00;
    fun_sel = 2'd3;
    tick();
    idle();
    tests++; if (o1_a !== 8'h11 || o2_a !== 8'h00) begin fails++; $display("FAIL restore_override r0=%h r2=%h exp=11/00", o1_a, o2_a); end
    tests++; if (ovf_a !== 1'b0) begin fails++; $display("FAIL restore_no_ovf Ovf=%b exp=0", ovf_a); end
  endtask

  task automatic test_swap();
    o1_sel = 3'd0;
    load(3'd0, 8'h55);
    snap = 1'b1;
    tick();
    idle();
    load(3'd0, 8'hAA);
    snap    = 1'b1;
    restore = 1'b1;
    tick();
    idle();
    tests++; if (o1_a !== 8'h55) begin fails++; $display("FAIL swap r0=%h exp=55", o1_a); end
    restore = 1'b1;
    tick();
    idle();
    tests++; if (o1_a !== 8'hAA) begin fails++; $display("FAIL swap_back r0=%h exp=aa", o1_a); end
  endtask

  task automatic test_reset_abort();
    o1_sel  = 3'd1;
    o2_sel  = 3'd0;
    r_sel   = 8'hFD;
    fun_sel = 2'd2;
    tick();
    idle();
    tests++; if (o1_a !== 8'hFF || ovf_a !== 1'b1 || o2_a !== 8'hAA) begin fails++; $display("FAIL pre_abort r1=%h r0=%h Ovf=%b exp=ff/aa/1", o1_a, o2_a, ovf_a); end
    restore = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    tests++; if (o1_a !== 8'h00 || o2_a !== 8'h00 || ovf_a !== 1'b0 || z1_a !== 1'b1) begin fails++; $display("FAIL async_reset r1=%h r0=%h Ovf=%b Z1=%b exp=00/00/0/1", o1_a, o2_a, ovf_a, z1_a); end
    tick();
    rst = 1'b0;
    tick();
    idle();
    tests++; if (o1_a !== 8'h00 || o2_a !== 8'h00 || ovf_a !== 1'b0) begin fails++; $display("FAIL restore_after_reset r1=%h r0=%h Ovf=%b exp=00/00/0", o1_a, o2_a, ovf_a); end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    o1_sel = 3'd0;
    o2_sel = 3'd0;
    test_reset();
    test_load();
    test_inc_overflow();
    test_dec_clrovf();
    test_snap_restore();
    test_swap();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gen_reg_file.md
GEN_REG_FILE -- requirements
Module: gen_reg_file

Interface
REQ-001 Parameter WIDTH, default 8, register bit width (>=2).
REQ-002 Parameter NREG, default 8, number of registers (power of 2, >=2); SW = log2(NREG).
REQ-003 Parameter SAT, default 0, inc/dec overflow mode: 0 = wrap, 1 = saturate.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 CLK  in  1  clock, all state updates on rising edge.
REQ-006 RST  in  1  asynchronous active-high reset.
REQ-007 FunSel  in  2  operation on enabled registers: 0 clear, 1 load I, 2 decrement, 3 increment.
REQ-008 RSel  in  NREG  per-register enable, active-low (bit k=0 enables register k).
REQ-009 I  in  WIDTH  load data.
REQ-010 O1Sel, O2Sel  in  SW each  read-port selects.
REQ-011 Snap  in  1  copy all registers into shadow bank.
REQ-012 Restore  in  1  copy shadow bank into all registers.
REQ-013 ClrOvf  in  1  clear sticky overflow flag.
REQ-014 O1, O2  out  WIDTH each  read-port data.
REQ-015 Z1  out  1  high when O1 == 0.
REQ-016 Ovf  out  1  sticky overflow/underflow flag.

Function
REQ-017 O1/O2/Z1 combinational from current register contents; no write-to-read bypass (written value visible the cycle after the edge).
REQ-018 Any O1Sel/O2Sel change, or register change, SHALL update O1/O2 in the same cycle (full sensitivity, no stale latching).
REQ-019 At an edge with Restore=0, each register with RSel[k]=0 SHALL take the FunSel result; registers with RSel[k]=1 hold.
REQ-020 Decrement/increment modulo 2^WIDTH when SAT=0; when SAT=1, clamp at 0 / 2^WIDTH-1.
REQ-021 Ovf SHALL set at an edge where any enabled register decrements from 0 or increments from 2^WIDTH-1 (both modes).
REQ-022 Ovf clears at an edge with ClrOvf=1 unless REQ-021 also sets it that edge (set wins).
REQ-023 Restore=1 SHALL load every register from shadow, overriding FunSel/RSel that edge; Ovf not set by a restore.
REQ-024 Snap=1 SHALL load shadow from pre-edge register values.
REQ-025 Snap=1 and Restore=1 together SHALL swap register and shadow banks in one edge.
REQ-026 Snap with concurrent FunSel write (Restore=0): shadow gets pre-write values, registers get written values.
REQ-027 Shadow bank not readable directly; state fully determined by REQ-023..026.
REQ-028 Latency: write, snap, restore take effect in exactly 1 clock; no busy state, accepts an operation every cycle.

Reset
REQ-029 RST=1 SHALL immediately (no clock) force all registers and shadow entries to 0 and Ovf to 0; hence O1=O2=0, Z1=1.
REQ-030 While RST=1 all inputs ignored; first edge after RST falls processes inputs normally.
REQ-031 RST asserted mid-operation (concurrent Snap/Restore/write) SHALL abort it; no partial update survives.

Verification (WIDTH=8, NREG=8)
REQ-032 Reset then RSel=8'hFE, FunSel=1, I=8'h5A, 1 edge; O1Sel=0 -> O1=8'h5A, Z1=0, other registers 0.
REQ-033 SAT=0: reg3=8'hFF, FunSel=3 enabled -> reg3=8'h00, Ovf=1; ClrOvf=1 next edge with no enables -> Ovf=0; SAT=1 same stimulus -> reg3=8'hFF, Ovf=1.
REQ-034 reg0=8'h11, Snap=1; then load reg0=8'h22; Restore=1 -> reg0=8'h11 after that edge.
REQ-035 reg0=8'hAA, shadow0=8'h55, Snap=1 and Restore=1 same edge -> reg0=8'h55, later Restore -> reg0=8'hAA.
REQ-036 reg1=8'h00, FunSel=2 on reg1 with ClrOvf=1 same edge -> reg1=8'hFF (SAT=0), Ovf=1.
REQ-037 RST pulsed between edges during Restore=1 with nonzero shadow -> all outputs 0, Ovf=0 immediately; subsequent Restore -> registers remain 0.
